// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the privilege / context-swap controller: FSM states,
// trap cause codes, pc_operation encodings and the default handler vector.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_KERNEL,
        ST_ENTER,
        ST_USER,
        ST_TRAP,
        ST_SAVE
    } ctx_state_e;

    localparam int unsigned CAUSE_QUANTUM  = 1;
    localparam int unsigned CAUSE_SYSCALL  = 2;
    localparam int unsigned CAUSE_IRQ_BASE = 8;

    localparam logic [1:0] PC_OP_NONE = 2'b00;
    localparam logic [1:0] PC_OP_SAVE = 2'b01;

    localparam logic [31:0] ISR_VECTOR_DEFAULT = 32'd1;

    localparam int unsigned QCNT_WIDTH = 16;

endpackage

// File: rtl/irq_pending_latch.sv
// Sticky IRQ pending bits with lowest-index priority and clear-on-take.
// Live irq levels are merged in so a request can be taken in the cycle it rises.
module irq_pending_latch #(
    parameter int unsigned IRQ_WIDTH = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hlt,
    input  logic [IRQ_WIDTH-1:0] irq,
    input  logic                 take,
    output logic                 any_c,
    output logic [IDX_WIDTH-1:0] idx_c
);

    logic [IRQ_WIDTH-1:0] pend;
    logic [IRQ_WIDTH-1:0] merged;
    logic [IRQ_WIDTH-1:0] take_mask;

    assign merged = pend | irq;
    assign any_c  = |merged;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        idx_c = '0;
        for (int i = IRQ_WIDTH - 1; i >= 0; i--) begin
            if (merged[i]) begin
                idx_c = IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        take_mask = '0;
        if (take) begin
            take_mask[idx_c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (!hlt) begin
            pend <= merged & ~take_mask;
        end
    end

endmodule

// File: rtl/context_swap_controller.sv
// Kernel/process context-swap controller in front of the register bank.
// Optional preemption quantum timer enabled by defining CTX_QUANTUM_TIMER_EN.
module context_swap_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned INTRPT_WIDTH = 6,
    parameter int unsigned SIGNAL_WIDTH = 2,
    parameter int unsigned IRQ_WIDTH    = 4,
    parameter int unsigned QUANTUM      = 1024,
    parameter logic [DATA_WIDTH-1:0] ISR_VECTOR = DATA_WIDTH'(ISR_VECTOR_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hlt,
    input  logic [IRQ_WIDTH-1:0]    irq,
    input  logic                    syscall,
    input  logic                    exec_user,
    input  logic                    resume,
    input  logic                    save_ctx,
    input  logic [DATA_WIDTH-1:0]   user_pc,
    input  logic [DATA_WIDTH-1:0]   pc_in,
    output logic [INTRPT_WIDTH-1:0] intrpt,
    output logic [SIGNAL_WIDTH-1:0] pc_operation,
    output logic [DATA_WIDTH-1:0]   PROC_PC,
    output logic                    read_shift_enabler,
    output logic                    write_shift_enabler,
    output logic                    pc_redirect,
    output logic [DATA_WIDTH-1:0]   redirect_addr,
    output logic                    user_mode
);

    localparam int unsigned IDX_WIDTH = (IRQ_WIDTH > 1) ? $clog2(IRQ_WIDTH) : 1;

    if (QUANTUM < 2 || QUANTUM > 65536) begin : g_bad_quantum
        $error("context_swap_controller: QUANTUM must lie in 2..65536");
    end

    ctx_state_e state;
    ctx_state_e state_d;

    logic                    irq_any_c;
    logic [IDX_WIDTH-1:0]    irq_idx_c;
    logic                    irq_take_c;
    logic                    quantum_exp_c;
    logic                    trap_c;

    logic [INTRPT_WIDTH-1:0] cause_q;
    logic [INTRPT_WIDTH-1:0] cause_d;
    logic [DATA_WIDTH-1:0]   trap_pc_q;
    logic [DATA_WIDTH-1:0]   trap_pc_d;
    logic [DATA_WIDTH-1:0]   target_q;
    logic [DATA_WIDTH-1:0]   target_d;

    logic [INTRPT_WIDTH-1:0] intrpt_d;
    logic [SIGNAL_WIDTH-1:0] pc_operation_d;
    logic [DATA_WIDTH-1:0]   proc_pc_d;
    logic                    enabler_d;
    logic                    pc_redirect_d;
    logic [DATA_WIDTH-1:0]   redirect_addr_d;
    logic                    user_mode_d;

    irq_pending_latch #(
        .IRQ_WIDTH (IRQ_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_irq_pending (
        .clk   (clk),
        .rst_n (rst_n),
        .hlt   (hlt),
        .irq   (irq),
        .take  (irq_take_c),
        .any_c (irq_any_c),
        .idx_c (irq_idx_c)
    );

`ifdef CTX_QUANTUM_TIMER_EN
    localparam logic [QCNT_WIDTH-1:0] QUANTUM_RELOAD = QCNT_WIDTH'(QUANTUM - 1);

    logic [QCNT_WIDTH-1:0] quantum_cnt;

    // Reloaded on every entry to USER; parks at zero until the trap is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quantum_cnt <= '0;
        end else if (!hlt) begin
            if (state == ST_ENTER) begin
                quantum_cnt <= QUANTUM_RELOAD;
            end else if (state == ST_USER && quantum_cnt != '0) begin
                quantum_cnt <= quantum_cnt - QCNT_WIDTH'(1);
            end
        end
    end

    assign quantum_exp_c = (quantum_cnt == '0);
`else
    assign quantum_exp_c = 1'b0;
`endif

    assign trap_c = irq_any_c | syscall | quantum_exp_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_KERNEL;
        end else if (!hlt) begin
            state <= state_d;
        end
    end

    // Outputs are computed from the current state and registered, so each
    // state's outputs become visible on the edge that leaves that state.
    always_comb begin
        state_d         = state;
        irq_take_c      = 1'b0;
        cause_d         = cause_q;
        trap_pc_d       = trap_pc_q;
        target_d        = target_q;
        intrpt_d        = '0;
        pc_operation_d  = SIGNAL_WIDTH'(PC_OP_NONE);
        proc_pc_d       = PROC_PC;
        enabler_d       = 1'b0;
        pc_redirect_d   = 1'b0;
        redirect_addr_d = redirect_addr;
        user_mode_d     = 1'b0;

        case (state)
            ST_KERNEL: begin
                if (exec_user) begin
                    state_d  = ST_ENTER;
                    target_d = user_pc;
                end else if (resume) begin
                    state_d  = ST_ENTER;
                    target_d = PROC_PC;
                end else if (save_ctx) begin
                    state_d = ST_SAVE;
                end
            end
            ST_ENTER: begin
                state_d         = ST_USER;
                enabler_d       = 1'b1;
                pc_redirect_d   = 1'b1;
                redirect_addr_d = target_q;
            end
            ST_USER: begin
                enabler_d   = 1'b1;
                user_mode_d = 1'b1;
                if (trap_c) begin
                    state_d = ST_TRAP;
                    if (irq_any_c) begin
                        irq_take_c = 1'b1;
                        cause_d    = INTRPT_WIDTH'(CAUSE_IRQ_BASE) + INTRPT_WIDTH'(irq_idx_c);
                        trap_pc_d  = pc_in;
                    end else if (syscall) begin
                        cause_d   = INTRPT_WIDTH'(CAUSE_SYSCALL);
                        trap_pc_d = pc_in + DATA_WIDTH'(1);
                    end else begin
                        cause_d   = INTRPT_WIDTH'(CAUSE_QUANTUM);
                        trap_pc_d = pc_in;
                    end
                end
            end
            ST_TRAP: begin
                state_d         = ST_KERNEL;
                intrpt_d        = cause_q;
                proc_pc_d       = trap_pc_q;
                pc_redirect_d   = 1'b1;
                redirect_addr_d = ISR_VECTOR;
            end
            ST_SAVE: begin
                state_d        = ST_KERNEL;
                pc_operation_d = SIGNAL_WIDTH'(PC_OP_SAVE);
            end
            default: begin
                state_d = ST_KERNEL;
            end
        endcase
    end

    // Halt holds levels but drops the one-cycle strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cause_q             <= '0;
            trap_pc_q           <= '0;
            target_q            <= '0;
            intrpt              <= '0;
            pc_operation        <= '0;
            PROC_PC             <= '0;
            read_shift_enabler  <= 1'b0;
            write_shift_enabler <= 1'b0;
            pc_redirect         <= 1'b0;
            redirect_addr       <= '0;
            user_mode           <= 1'b0;
        end else if (!hlt) begin
            cause_q             <= cause_d;
            trap_pc_q           <= trap_pc_d;
            target_q            <= target_d;
            intrpt              <= intrpt_d;
            pc_operation        <= pc_operation_d;
            PROC_PC             <= proc_pc_d;
            read_shift_enabler  <= enabler_d;
            write_shift_enabler <= enabler_d;
            pc_redirect         <= pc_redirect_d;
            redirect_addr       <= redirect_addr_d;
            user_mode           <= user_mode_d;
        end else begin
            intrpt       <= '0;
            pc_operation <= SIGNAL_WIDTH'(PC_OP_NONE);
            pc_redirect  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_context_swap_controller.sv
// Self-checking bench for context_swap_controller; adapts to CTX_QUANTUM_TIMER_EN.
// The reference model tracks mode, pending IRQ set and saved PC per transaction.
module tb_context_swap_controller;

    localparam int unsigned Q = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hlt;
    logic [3:0]  irq;
    logic        syscall;
    logic        exec_user;
    logic        resume;
    logic        save_ctx;
    logic [31:0] user_pc;
    logic [31:0] pc_in;
    logic [5:0]  intrpt;
    logic [1:0]  pc_operation;
    logic [31:0] PROC_PC;
    logic        read_shift_enabler;
    logic        write_shift_enabler;
    logic        pc_redirect;
    logic [31:0] redirect_addr;
    logic        user_mode;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  m_pend;
    logic [31:0] m_proc_pc;

    always #5 clk = ~clk;

    context_swap_controller #(
        .DATA_WIDTH   (32),
        .INTRPT_WIDTH (6),
        .SIGNAL_WIDTH (2),
        .IRQ_WIDTH    (4),
        .QUANTUM      (Q),
        .ISR_VECTOR   (32'd1)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .hlt                 (hlt),
        .irq                 (irq),
        .syscall             (syscall),
        .exec_user           (exec_user),
        .resume              (resume),
        .save_ctx            (save_ctx),
        .user_pc             (user_pc),
        .pc_in               (pc_in),
        .intrpt              (intrpt),
        .pc_operation        (pc_operation),
        .PROC_PC             (PROC_PC),
        .read_shift_enabler  (read_shift_enabler),
        .write_shift_enabler (write_shift_enabler),
        .pc_redirect         (pc_redirect),
        .redirect_addr       (redirect_addr),
        .user_mode           (user_mode)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cause rule: lowest pending IRQ k -> 8+k, else syscall -> 2, else quantum -> 1.
    function automatic logic [5:0] exp_cause(input logic [3:0] pend, input logic sc,
                                             input logic qexp);
        for (int k = 0; k < 4; k++) begin
            if (pend[k]) return 6'(8 + k);
        end
        if (sc) return 6'd2;
        if (qexp) return 6'd1;
        return 6'd0;
    endfunction

    // Kernel request then check the ENTER strobe one cycle later.
    task automatic launch(input logic [31:0] addr, input logic is_resume);
        if (is_resume) resume = 1'b1;
        else begin
            exec_user = 1'b1;
            user_pc   = addr;
        end
        tick();
        exec_user = 1'b0;
        resume    = 1'b0;
        user_pc   = $urandom;
        n_checks++;
        if (pc_redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL launch_early_redirect: got %b expected 0", pc_redirect);
        end
        tick();
        n_checks++;
        if ({pc_redirect, redirect_addr, read_shift_enabler, write_shift_enabler}
            !== {1'b1, addr, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL launch_enter: redirect=%b addr=%h en=%b%b expected 1 %h 11",
                     pc_redirect, redirect_addr, read_shift_enabler, write_shift_enabler, addr);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            n_checks++;
            if ({intrpt, user_mode, pc_redirect} !== {6'd0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL user_idle: intrpt=%0d user_mode=%b redirect=%b expected 0 1 0",
                         intrpt, user_mode, pc_redirect);
            end
        end
    endtask

    // Present a trap condition at the next edge (state must be USER) and check TRAP outputs.
    task automatic fire_trap(input logic [3:0] irq_v, input logic sc, input logic [31:0] pc,
                             input logic qexp);
        logic [3:0]  eff;
        logic [5:0]  cause;
        logic [31:0] exp_pc;
        eff    = m_pend | irq_v;
        cause  = exp_cause(eff, sc, qexp);
        exp_pc = (cause == 6'd2) ? pc + 32'd1 : pc;
        if (cause >= 6'd8) m_pend = eff & ~(4'b0001 << (cause - 6'd8));
        else               m_pend = eff;
        irq     = irq_v;
        syscall = sc;
        pc_in   = pc;
        tick();
        irq     = 4'b0;
        syscall = 1'b0;
        pc_in   = $urandom;
        tick();
        n_checks++;
        if (intrpt !== cause) begin
            n_fail++;
            $display("FAIL trap_cause: got %0d expected %0d", intrpt, cause);
        end
        n_checks++;
        if (PROC_PC !== exp_pc) begin
            n_fail++;
            $display("FAIL trap_proc_pc: got %h expected %h", PROC_PC, exp_pc);
        end
        n_checks++;
        if ({pc_redirect, redirect_addr, read_shift_enabler, write_shift_enabler, user_mode}
            !== {1'b1, 32'd1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL trap_redirect: redirect=%b addr=%h en=%b%b um=%b expected 1 1 00 0",
                     pc_redirect, redirect_addr, read_shift_enabler, write_shift_enabler,
                     user_mode);
        end
        m_proc_pc = exp_pc;
        tick();
        n_checks++;
        if ({intrpt, pc_redirect} !== 7'd0) begin
            n_fail++;
            $display("FAIL trap_pulse_width: intrpt=%0d redirect=%b expected 0 0",
                     intrpt, pc_redirect);
        end
    endtask

    task automatic drain();
        while (m_pend != 4'b0) begin
            launch(m_proc_pc, 1'b1);
            fire_trap(4'b0, 1'b0, $urandom, 1'b0);
        end
    endtask

    task automatic do_save();
        save_ctx = 1'b1;
        tick();
        save_ctx = 1'b0;
        tick();
        n_checks++;
        if (pc_operation !== 2'b01) begin
            n_fail++;
            $display("FAIL save_pc_op: got %b expected 01", pc_operation);
        end
        tick();
        n_checks++;
        if (pc_operation !== 2'b00) begin
            n_fail++;
            $display("FAIL save_pulse_width: got %b expected 00", pc_operation);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({intrpt, pc_operation, PROC_PC} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_regs: intrpt=%0d pc_op=%b proc_pc=%h expected 0",
                     intrpt, pc_operation, PROC_PC);
        end
        n_checks++;
        if ({read_shift_enabler, write_shift_enabler, pc_redirect, redirect_addr, user_mode}
            !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: en=%b%b redirect=%b addr=%h um=%b expected 0",
                     read_shift_enabler, write_shift_enabler, pc_redirect, redirect_addr,
                     user_mode);
        end
        rst_n     = 1'b1;
        m_pend    = 4'b0;
        m_proc_pc = 32'd0;
    endtask

    task automatic test_launch_syscall();
        launch(32'h40, 1'b0);
        tick();
        n_checks++;
        if ({user_mode, pc_redirect, read_shift_enabler} !== 3'b101) begin
            n_fail++;
            $display("FAIL user_mode_entry: um=%b redirect=%b en=%b expected 1 0 1",
                     user_mode, pc_redirect, read_shift_enabler);
        end
        // Kernel requests raised while in USER have no effect.
        exec_user = 1'b1;
        save_ctx  = 1'b1;
        user_pc   = 32'h999;
        tick();
        exec_user = 1'b0;
        save_ctx  = 1'b0;
        n_checks++;
        if ({pc_redirect, pc_operation, user_mode} !== 4'b0001) begin
            n_fail++;
            $display("FAIL kernel_req_ignored: redirect=%b pc_op=%b um=%b expected 0 00 1",
                     pc_redirect, pc_operation, user_mode);
        end
        fire_trap(4'b0, 1'b1, 32'h45, 1'b0);
        do_save();
    endtask

    task automatic test_irq_priority();
        launch(32'h100, 1'b0);
        fire_trap(4'b0110, 1'b1, 32'h200, 1'b0);
        n_checks++;
        if (m_proc_pc !== 32'h200 || m_pend !== 4'b0100) begin
            n_fail++;
            $display("FAIL model_irq_prio: pc=%h pend=%b expected 200 0100", m_proc_pc, m_pend);
        end
        launch(m_proc_pc, 1'b1);
        fire_trap(4'b0, 1'b0, 32'h200, 1'b0);
    endtask

    task automatic test_quantum();
`ifdef CTX_QUANTUM_TIMER_EN
        // Q USER cycles after ENTER, then the registered TRAP outputs.
        launch(32'h300, 1'b0);
        idle(Q - 1);
        fire_trap(4'b0, 1'b0, 32'h333, 1'b1);
        // Expiry coinciding with an IRQ is dropped; the next ENTER reloads.
        launch(32'h380, 1'b0);
        idle(Q - 1);
        fire_trap(4'b0001, 1'b0, 32'h388, 1'b1);
        launch(m_proc_pc, 1'b1);
        idle(Q - 1);
        fire_trap(4'b0, 1'b0, 32'h390, 1'b1);
`else
        launch(32'h300, 1'b0);
        idle(100);
        fire_trap(4'b0, 1'b1, 32'h333, 1'b0);
`endif
    endtask

    task automatic test_halt();
        launch(32'h500, 1'b0);
        idle(2);
        hlt     = 1'b1;
        irq     = 4'b0001;
        syscall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({intrpt, user_mode, pc_redirect} !== {6'd0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL halt_hold: intrpt=%0d um=%b redirect=%b expected 0 1 0",
                         intrpt, user_mode, pc_redirect);
            end
        end
        hlt     = 1'b0;
        irq     = 4'b0;
        syscall = 1'b0;
`ifdef CTX_QUANTUM_TIMER_EN
        idle(Q - 3);
        fire_trap(4'b0, 1'b0, 32'h555, 1'b1);
`else
        idle(10);
        fire_trap(4'b0, 1'b1, 32'h555, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_trap();
        launch(32'h600, 1'b0);
        irq   = 4'b1001;
        pc_in = 32'h611;
        tick();
        irq   = 4'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({intrpt, pc_redirect, PROC_PC, read_shift_enabler, user_mode} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_mid_trap: intrpt=%0d redirect=%b proc_pc=%h en=%b um=%b expected 0",
                     intrpt, pc_redirect, PROC_PC, read_shift_enabler, user_mode);
        end
        m_pend    = 4'b0;
        m_proc_pc = 32'd0;
        launch(32'h700, 1'b0);
        idle(Q - 2);
        fire_trap(4'b0, 1'b1, 32'h710, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] irq_v;
        logic       sc;
        for (int it = 0; it < 20; it++) begin
            launch($urandom, 1'b0);
            idle($urandom_range(0, 5));
            irq_v = 4'($urandom_range(0, 15));
            sc    = 1'($urandom_range(0, 1));
            if (irq_v == 4'b0) sc = 1'b1;
            fire_trap(irq_v, sc, $urandom, 1'b0);
            drain();
            if ($urandom_range(0, 1) == 1) do_save();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        hlt       = 1'b0;
        irq       = 4'b0;
        syscall   = 1'b0;
        exec_user = 1'b0;
        resume    = 1'b0;
        save_ctx  = 1'b0;
        user_pc   = 32'd0;
        pc_in     = 32'd0;
        m_pend    = 4'b0;
        m_proc_pc = 32'd0;
        test_reset();
        test_launch_syscall();
        test_irq_priority();
        test_quantum();
        test_halt();
        test_reset_mid_trap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/context_swap_controller.md
# context_swap_controller

Privilege and context-swap controller sitting directly upstream of the register bank. It selects the kernel or process register half by driving `read_shift_enabler` and `write_shift_enabler`, and writes interruption causes and saved process PCs into r28 through the bank's `intrpt` / `pc_operation` / `PROC_PC` inputs. It also redirects the PC unit on trap entry and on process launch or resume. Trap sources are external IRQ lines, the syscall instruction and an optional preemption quantum timer.

## Interface
- `DATA_WIDTH`, 32, PC and address width
- `INTRPT_WIDTH`, 6, cause code width; matches the register bank
- `SIGNAL_WIDTH`, 2, `pc_operation` width
- `IRQ_WIDTH`, 4, number of external interrupt lines
- `QUANTUM`, 1024, preemption quantum in cycles (2..2^16)
- `ISR_VECTOR`, 32'd1, kernel handler entry address
- `clk` in 1: the single clock, same divided clock as the register bank write clock
- `rst_n` in 1: reset, synchronous and active-low
- `hlt` in 1: freezes the FSM, quantum counter and pending capture
- `irq` in IRQ_WIDTH: level interrupt requests
- `syscall` in 1: syscall instruction executing this cycle
- `exec_user` in 1: kernel request to launch a process at `user_pc`
- `resume` in 1: kernel request to return to the process at the stored `PROC_PC`
- `save_ctx` in 1: kernel request to copy `PROC_PC` into r28
- `user_pc` in DATA_WIDTH: launch address
- `pc_in` in DATA_WIDTH: PC of the instruction currently executing
- `intrpt` out INTRPT_WIDTH: cause code, nonzero for one cycle per trap
- `pc_operation` out SIGNAL_WIDTH: 2'b01 = save `PROC_PC` to r28, 2'b00 = none
- `PROC_PC` out DATA_WIDTH: saved process PC
- `read_shift_enabler` out 1: selects the process half when 1
- `write_shift_enabler` out 1: selects the process half when 1
- `pc_redirect` out 1: one-cycle PC load strobe
- `redirect_addr` out DATA_WIDTH: PC load value
- `user_mode` out 1: high in USER

## Operation
- **States:** KERNEL, ENTER, USER, TRAP, SAVE. All outputs are registered.
- **Reset:** state KERNEL; every output is 0; pending bits, stored cause and quantum counter are cleared.
- **KERNEL:** both enablers 0.
  - Request priority: `exec_user` > `resume` > `save_ctx`.
  - `exec_user` → ENTER. `redirect_addr` = `user_pc`.
  - `resume` → ENTER. `redirect_addr` = `PROC_PC`.
  - `save_ctx` → SAVE.
  - Kernel requests outside KERNEL are ignored.
- **ENTER (1 cycle):** `pc_redirect` = 1, both enablers = 1, quantum counter reloaded to `QUANTUM`-1, then → USER.
- **USER:** the counter decrements each non-halted cycle.
  - Trap priority: lowest-index pending IRQ > `syscall` > quantum expiry (counter == 0). Any trap → TRAP.
  - Cause codes: IRQ k = 8+k, syscall = 2, quantum = 1.
- **TRAP (1 cycle):**
  - `PROC_PC` ← `pc_in` of the interrupted cycle, so resume re-executes that instruction. Exception: a syscall trap stores `pc_in`+1.
  - `intrpt` = cause, which the bank writes to kernel r28.
  - Both enablers = 0, `pc_redirect` = 1, `redirect_addr` = `ISR_VECTOR`.
  - The taken pending bit is cleared. Then → KERNEL.
- **SAVE (1 cycle):** `pc_operation` = 2'b01, so r28 ← `PROC_PC`. Then → KERNEL.
- **Pending IRQs:** `irq` bits set sticky pending bits in any state, so an IRQ raised in KERNEL is taken on the first USER cycle. A pending bit is cleared only when its trap is taken, or by reset.
- **Simultaneous events:**
  - An IRQ coinciding with `syscall` traps as the IRQ; the syscall is re-executed after resume.
  - A quantum expiry coinciding with an IRQ is dropped; the counter reloads on the next ENTER.
- **`hlt`:** holds state, counter and outputs unchanged; one-cycle pulses are not emitted while halted.
- **Reset mid-operation:** `rst_n` low in any state, including TRAP or SAVE, forces KERNEL with all outputs 0 on the next edge.

## Timing
- Trap request sampled in USER at edge N: TRAP outputs valid after edge N+1, KERNEL after edge N+2.
- The instruction in USER at cycle N still writes the process half.
- Launch: `exec_user` at N, ENTER at N+1, first user instruction at N+2.
- `intrpt`, `pc_redirect` and `pc_operation` are each exactly one cycle wide.
- Minimum quantum is 2 cycles.

## Configuration
- Macro: `CTX_QUANTUM_TIMER_EN`.
- **Defined:** the quantum counter and cause 1 exist.
- **Undefined:** no counter is instantiated, USER never preempts on its own, and cause 1 is never produced.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - state enum
  - cause codes
  - `pc_operation` encodings
  - `ISR_VECTOR` default
- Sub-module `irq_pending_latch`: sticky pending bits, lowest-index priority encoder, clear-on-take.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles → all outputs 0, state KERNEL.
- **Launch:** `exec_user`, `user_pc`=0x40 → `pc_redirect` with 0x40 one cycle later, enablers =1, `user_mode`=1.
- **Syscall:** syscall in USER at `pc_in`=0x45 → `intrpt`=2 for one cycle, `PROC_PC`=0x46, redirect 0x1. Then `save_ctx` → `pc_operation`=01 for one cycle.
- **IRQ priority:** `irq`=4'b0110 with `syscall` same cycle → cause 9. Bit 2 remains pending. After `resume` → immediate TRAP with cause 10.
- **Quantum:** with `CTX_QUANTUM_TIMER_EN` and `QUANTUM`=8 → `intrpt`=1 exactly 8 USER cycles after ENTER. Without the macro → no trap over 100 cycles.
- **Reset mid-trap and halt:** `rst_n`=0 during TRAP → outputs 0 next cycle, pending cleared. `hlt` in USER for 5 cycles → counter frozen.
